// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done request bus between a requester and the serial adder
interface serial_adder_if #(parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  output logic cout,
  output logic s,
  input  logic x,
  input  logic y,
  input  logic cin
);
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {1'b0, cin};
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full_adder cell to add two WIDTH-bit operands LSB first
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_cout, last;
  full_adder u_fa (.cout(fa_cout), .s(fa_s), .x(a_q[0]), .y(b_q[0]), .cin(carry_q));
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      s_d     = (s_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      carry_d = fa_cout;
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        sum_d   = s_d;
        cout_d  = fa_cout;
      end
    end else if (bus.start) begin
      state_d = RUN;
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  // status comes straight from the state so reset clears it without waiting for an edge
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences one instance of the team's one-bit `full_adder` cell to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It sits between a requester issuing `start` with operands and the single adder cell. It owns the operand shift registers, the carry flop, the bit counter and the start/busy/done handshake, trading WIDTH cycles of latency for one adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 1.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result; holds until the next completion.
- cout  output  1  final carry-out; holds with `sum`.

## Operation
- Reset: the state machine goes to IDLE. `busy`, `done`, `sum`, `cout`, the shift registers, the carry flop and the counter all clear to 0.
- States:
  - IDLE: wait for a request.
  - RUN: process one bit per cycle.
  - DONE: one cycle; `done` is high.
- Transitions:
  - IDLE or DONE with `start`=1 → RUN. On that edge, load A←a, B←b, carry←cin and cnt←0.
  - IDLE with `start`=0 → IDLE.
  - DONE with `start`=0 → IDLE.
  - RUN with cnt < WIDTH-1 → RUN.
  - RUN with cnt = WIDTH-1 → DONE.
- Each RUN edge:
  - The adder inputs are x=A[0], y=B[0], cin=carry.
  - S is shifted right, with the adder's `s` entering S[WIDTH-1].
  - A and B shift right by one; 0 enters the MSB.
  - carry ← the adder's `cout`.
  - cnt ← cnt+1.
- Completion: on the RUN→DONE edge, `sum` ← the final S (including the last bit) and `cout` ← the last adder carry. `sum` and `cout` change only on this edge.
- Arithmetic: {cout,sum} = a + b + cin, exact, with no overflow loss. The counter is $clog2(WIDTH)+1 bits wide.
- `start` in RUN is ignored: no restart, no operand recapture, and no error flag.
- Inputs `a`, `b` and `cin` may change freely after the accepted edge.
- `done` is never asserted except in the DONE state.

## Timing
- Let edge k be the edge on which `start` is accepted.
- `busy` is high for exactly WIDTH cycles, from after edge k through edge k+WIDTH.
- `done`, `sum` and `cout` become valid after edge k+WIDTH. Latency from start to done is WIDTH cycles.
- Back-to-back operation: `start` held high in DONE is accepted at edge k+WIDTH+1. The throughput is then WIDTH+1 cycles per operation, and `done` still pulses for exactly one cycle.
- WIDTH=1: a single RUN cycle; `done` follows one edge after the accepted start.
- Reset asserted mid-RUN: all outputs clear immediately (asynchronously). The operation is abandoned, no `done` is produced, and the state is IDLE after deassertion.
- Reset deasserted with `start` high: that start is accepted on the first clean edge.

## Structure
- Package `serial_adder_pkg`:
  - the `state_t` enum (IDLE, RUN, DONE) with a 2-bit encoding;
  - the default WIDTH constant.
- Single sub-module: the existing `full_adder`, instantiated once and port-mapped by name (`cout`, `s`, `x`, `y`, `cin`).
- All sequencing, counting and shift logic is local to `serial_adder_ctrl`.

## Test plan
- WIDTH=8, a=0x3C, b=0x42, cin=0 → `done` exactly 8 cycles after the accepted start edge; sum=0x7E, cout=0; `busy` high for 8 cycles.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. This checks the full carry ripple through every bit; then a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1.
- WIDTH=8, `start` re-pulsed with a=0x11, b=0x11 mid-RUN of 0x3C+0x42 → ignored; the result is 0x7E/0 and only one `done` pulse occurs.
- WIDTH=8, `start` held high continuously with fixed operands 0x01+0x02 → a `done` pulse every 9 cycles, sum=0x03 each time.
- WIDTH=8, rst_n low at the 4th RUN cycle → `busy`, `done`, `sum` and `cout` read 0 immediately with no `done` pulse; a subsequent 0x10+0x20 gives sum=0x30.
- WIDTH=1, all 8 {a,b,cin} combinations → {cout,sum} matches the full-adder truth table; `done` appears 1 cycle after each start.
